// File: rtl/spc_pkg.sv
// ----------------------------------------------------------------------------
// spc_pkg
// Shared definitions for the SPC file loader / ARAM block:
//   - loader state enumeration
//   - file region boundaries (header, ARAM image, DSP register image)
//   - header field offsets (ID666 tag, CPU registers, length, fade)
//   - the "SNES-SPC700" signature and a byte-select helper for it
// ----------------------------------------------------------------------------
package spc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ARAM,
        ST_DSP,
        ST_DONE,
        ST_ERR
    } spc_state_e;

    // File region starts (17-bit file offsets)
    localparam logic [16:0] ARAM_OFF   = 17'h00100;
    localparam logic [16:0] DSP_OFF    = 17'h10100;
    localparam logic [16:0] END_OFF    = 17'h10180;

    // Header field offsets
    localparam logic [16:0] ID_TAG_OFF = 17'h00023;
    localparam logic [16:0] REGS_OFF   = 17'h00025;
    localparam logic [16:0] LEN_OFF    = 17'h000A9;
    localparam logic [16:0] FADE_OFF   = 17'h000AC;

    localparam logic [7:0]  ID_TAG     = 8'h1A;

    // File signature occupying offsets 0x00..0x0A
    localparam int          SIG_LEN    = 11;
    localparam logic [87:0] SPC_SIG    = "SNES-SPC700";

    // Character idx of the signature; character 0 sits in the top byte.
    function automatic logic [7:0] sig_byte(input logic [3:0] idx);
        logic [6:0] lsb;
        lsb = 7'(4'd10 - idx) << 3;
        return SPC_SIG[lsb +: 8];
    endfunction

endpackage

// File: rtl/spc_digit_acc.sv
// ----------------------------------------------------------------------------
// spc_digit_acc
// Decimal ASCII field accumulator for one ID666 text field.
// The field occupies DIGITS bytes starting at file offset FIELD_OFF. The first
// digit sets the value, each further digit computes v*10+d (saturating at
// 0xFFFF), and the first non-digit freezes the field. A non-digit first byte
// leaves DEFAULT in place.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset (value -> DEFAULT)
//   clear        restart the field at DEFAULT (new load)
//   en           a header byte is being accepted and parsing is allowed
//   off          file offset of the byte being accepted
//   data         byte being accepted
//   value        current field value
// ----------------------------------------------------------------------------
import spc_pkg::*;

module spc_digit_acc #(
    parameter logic [16:0] FIELD_OFF = LEN_OFF,
    parameter int          DIGITS    = 3,
    parameter logic [15:0] DEFAULT   = 16'd20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [16:0] off,
    input  logic [7:0]  data,
    output logic [15:0] value
);

    localparam logic [16:0] FIELD_END = FIELD_OFF + 17'(DIGITS);

    logic [15:0] value_q, value_d;
    logic        frozen_q, frozen_d;
    logic        in_field;
    logic        is_digit;
    logic [7:0]  diff;
    logic [19:0] next_val;

    assign in_field = (off >= FIELD_OFF) && (off < FIELD_END);
    assign is_digit = (data >= 8'h30) && (data <= 8'h39);
    assign diff     = data - 8'h30;
    // 20 bits hold 0xFFFF*10+9 without overflow, so the clamp below is exact.
    assign next_val = {4'b0, value_q} * 20'd10 + {16'b0, diff[3:0]};

    always_comb begin
        value_d  = value_q;
        frozen_d = frozen_q;
        if (clear) begin
            value_d  = DEFAULT;
            frozen_d = 1'b0;
        end else if (en && in_field && !frozen_q) begin
            if (!is_digit) begin
                frozen_d = 1'b1;
            end else if (off == FIELD_OFF) begin
                value_d = {12'b0, diff[3:0]};
            end else begin
                value_d = (next_val > 20'h0FFFF) ? 16'hFFFF : next_val[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q  <= DEFAULT;
            frozen_q <= 1'b0;
        end else begin
            value_q  <= value_d;
            frozen_q <= frozen_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/spc_aram.sv
// ----------------------------------------------------------------------------
// spc_aram
// Loads an SPC file from a byte stream into a 64 KiB ARAM and a 128-byte DSP
// register image, captures the SPC700 CPU registers from the header and
// (optionally) parses the ID666 length/fade text fields. Outside a load the
// ARAM is served to the SMP through a simple read/write port.
//
// Configuration: define SPC_ID666_EN to parse the ID666 length/fade fields;
// without it length/fade are the constant defaults.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ld_start                   pulse: restart loading at file offset 0
//   ld_valid, ld_data, ld_ready  byte stream handshake
//   ld_busy, ld_done, ld_err   loader status
//   aram_a, aram_din, aram_wr, aram_dout  SMP ARAM port (registered read)
//   dsp_a, dsp_dout            registered read of the DSP register image
//   spc_regs                   {SP, PSW, Y, X, A, PC}
//   length, fade               playback length (s) and fade (ms)
// ----------------------------------------------------------------------------
import spc_pkg::*;

module spc_aram #(
    parameter int LEN_DIGITS  = 3,
    parameter int FADE_DIGITS = 5,
    parameter int DEF_LENGTH  = 20,
    parameter int DEF_FADE    = 3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        ld_done,
    output logic        ld_err,
    input  logic [15:0] aram_a,
    input  logic [7:0]  aram_din,
    input  logic        aram_wr,
    output logic [7:0]  aram_dout,
    input  logic [6:0]  dsp_a,
    output logic [7:0]  dsp_dout,
    output logic [55:0] spc_regs,
    output logic [15:0] length,
    output logic [15:0] fade
);

    localparam logic [16:0] HDR_LAST  = ARAM_OFF - 17'd1;
    localparam logic [16:0] ARAM_LAST = DSP_OFF - 17'd1;
    localparam logic [16:0] DSP_LAST  = END_OFF - 17'd1;
    localparam logic [16:0] SIG_END   = 17'(SIG_LEN);
    localparam logic [16:0] REGS_END  = REGS_OFF + 17'd7;

    spc_state_e  state_q, state_d;
    logic [16:0] off_q, off_d;
    logic [55:0] regs_q, regs_d;
    logic [7:0]  aram_dout_q, aram_dout_d;
    logic [7:0]  dsp_dout_q, dsp_dout_d;

    logic [7:0]  aram_mem [0:65535];
    logic [7:0]  dsp_mem  [0:127];

    logic        accept;
    logic        in_regs;
    logic [2:0]  reg_idx;
    logic        mem_we;
    logic [15:0] mem_wa;
    logic [7:0]  mem_wd;
    logic        dsp_we;

    assign ld_busy  = (state_q == ST_HDR) || (state_q == ST_ARAM) || (state_q == ST_DSP);
    assign ld_ready = ld_busy;
    assign ld_done  = (state_q == ST_DONE);
    assign ld_err   = (state_q == ST_ERR);
    assign accept   = ld_valid && ld_ready;
    assign in_regs  = (off_q >= REGS_OFF) && (off_q < REGS_END);
    assign reg_idx  = 3'(off_q - REGS_OFF);

    // Loader sequencing: ld_start always wins and drops any byte offered in
    // the same cycle. Each accepted byte advances the offset; region ends
    // move the FSM on, and a signature mismatch parks it in ERR until the
    // next ld_start.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        regs_d  = regs_q;
        if (ld_start) begin
            state_d = ST_HDR;
            off_d   = '0;
        end else if (accept) begin
            off_d = off_q + 17'd1;
            unique case (state_q)
                ST_HDR: begin
                    if (off_q < SIG_END && ld_data != sig_byte(off_q[3:0])) begin
                        state_d = ST_ERR;
                    end else if (off_q == HDR_LAST) begin
                        state_d = ST_ARAM;
                    end
                    if (in_regs) begin
                        regs_d[{reg_idx, 3'b000} +: 8] = ld_data;
                    end
                end
                ST_ARAM: if (off_q == ARAM_LAST) state_d = ST_DSP;
                ST_DSP:  if (off_q == DSP_LAST)  state_d = ST_DONE;
                default: ;
            endcase
        end
    end

    // Single ARAM write port shared by loader and SMP. While loading the SMP
    // side is locked out completely; the loader address wraps in 16 bits so
    // file offset 0x100 lands on ARAM 0x0000.
    always_comb begin
        mem_we = aram_wr;
        mem_wa = aram_a;
        mem_wd = aram_din;
        if (ld_busy) begin
            mem_we = accept && !ld_start && (state_q == ST_ARAM);
            mem_wa = off_q[15:0] - ARAM_OFF[15:0];
            mem_wd = ld_data;
        end
    end

    assign dsp_we = accept && !ld_start && (state_q == ST_DSP);

    // SMP reads only when idle and not writing, so a read never observes a
    // write from the same cycle; otherwise the last read data is held.
    always_comb begin
        aram_dout_d = aram_dout_q;
        if (!ld_busy && !aram_wr) begin
            aram_dout_d = aram_mem[aram_a];
        end
        dsp_dout_d = dsp_mem[dsp_a];
    end

    // Memories carry no reset so their contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            aram_mem[mem_wa] <= mem_wd;
        end
        if (dsp_we) begin
            dsp_mem[off_q[6:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            off_q       <= '0;
            regs_q      <= '0;
            aram_dout_q <= '0;
            dsp_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            regs_q      <= regs_d;
            aram_dout_q <= aram_dout_d;
            dsp_dout_q  <= dsp_dout_d;
        end
    end

    assign aram_dout = aram_dout_q;
    assign dsp_dout  = dsp_dout_q;
    assign spc_regs  = regs_q;

`ifdef SPC_ID666_EN
    logic id_present_q, id_present_d;
    logic field_en;

    // The ID666 tag byte precedes both text fields, so its registered value
    // is settled before the first field byte arrives.
    always_comb begin
        id_present_d = id_present_q;
        if (ld_start) begin
            id_present_d = 1'b0;
        end else if (accept && state_q == ST_HDR && off_q == ID_TAG_OFF) begin
            id_present_d = (ld_data == ID_TAG);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_present_q <= 1'b0;
        end else begin
            id_present_q <= id_present_d;
        end
    end

    assign field_en = accept && !ld_start && (state_q == ST_HDR) && id_present_q;

    spc_digit_acc #(
        .FIELD_OFF (LEN_OFF),
        .DIGITS    (LEN_DIGITS),
        .DEFAULT   (16'(DEF_LENGTH))
    ) u_len_acc (
        .clk   (clk),
        .reset (reset),
        .clear (ld_start),
        .en    (field_en),
        .off   (off_q),
        .data  (ld_data),
        .value (length)
    );

    spc_digit_acc #(
        .FIELD_OFF (FADE_OFF),
        .DIGITS    (FADE_DIGITS),
        .DEFAULT   (16'(DEF_FADE))
    ) u_fade_acc (
        .clk   (clk),
        .reset (reset),
        .clear (ld_start),
        .en    (field_en),
        .off   (off_q),
        .data  (ld_data),
        .value (fade)
    );
`else
    assign length = 16'(DEF_LENGTH);
    assign fade   = 16'(DEF_FADE);
`endif

endmodule

// File: tb/tb_spc_aram.sv
// ----------------------------------------------------------------------------
// tb_spc_aram
// Self-checking bench for spc_aram: a table of header variants, a reset-abort
// sequence, one full file load, then random SMP/DSP traffic compared against
// an array model of ARAM and the DSP image.
// ----------------------------------------------------------------------------
module tb_spc_aram;

    localparam int LEN_DIGITS  = 3;
    localparam int FADE_DIGITS = 5;
    localparam int DEF_LENGTH  = 20;
    localparam int DEF_FADE    = 3000;
`ifdef SPC_ID666_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;
    logic [15:0] aram_a;
    logic [7:0]  aram_din;
    logic        aram_wr;
    logic [7:0]  aram_dout;
    logic [6:0]  dsp_a;
    logic [7:0]  dsp_dout;
    logic [55:0] spc_regs;
    logic [15:0] length;
    logic [15:0] fade;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ref_aram [65536];
    logic [7:0] ref_dsp  [128];
    logic [7:0] hdr      [256];

    typedef struct {
        int         bad_idx;
        logic [7:0] tag;
        string      len_s;
        string      fade_s;
        bit         exp_err;
        int         exp_len;
        int         exp_fade;
    } vec_t;

    vec_t vecs[8];

    spc_aram #(
        .LEN_DIGITS  (LEN_DIGITS),
        .FADE_DIGITS (FADE_DIGITS),
        .DEF_LENGTH  (DEF_LENGTH),
        .DEF_FADE    (DEF_FADE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
        .ld_err    (ld_err),
        .aram_a    (aram_a),
        .aram_din  (aram_din),
        .aram_wr   (aram_wr),
        .aram_dout (aram_dout),
        .dsp_a     (dsp_a),
        .dsp_dout  (dsp_dout),
        .spc_regs  (spc_regs),
        .length    (length),
        .fade      (fade)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run never reaches its summary.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input int bad, input logic [7:0] tag, input string ls,
                                   input string fs, input bit err, input int el, input int ef);
        vec_t v;
        v.bad_idx = bad; v.tag = tag; v.len_s = ls; v.fade_s = fs;
        v.exp_err = err; v.exp_len = el; v.exp_fade = ef;
        return v;
    endfunction

    // Reference parse of an ID666 decimal field.
    function automatic int expField(input string s, input int digits, input int def,
                                    input logic [7:0] tag);
        int v;
        v = def;
        for (int i = 0; i < digits; i++) begin
            int c;
            c = (i < s.len()) ? int'(s[i]) : 0;
            if (c < 48 || c > 57) break;
            v = (i == 0) ? (c - 48) : (v * 10 + c - 48);
            if (v > 65535) v = 65535;
        end
        return (ID_EN && tag == 8'h1A) ? v : def;
    endfunction

    function automatic logic [55:0] expRegs();
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r[i*8 +: 8] = hdr[37 + i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        ld_valid = v;
        ld_data  = d;
        tick();
    endtask

    task automatic startLoad();
        ld_valid = 1'b0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic readAram(input logic [15:0] a, output logic [7:0] d);
        aram_wr = 1'b0;
        aram_a  = a;
        tick();
        d = aram_dout;
    endtask

    task automatic writeAram(input logic [15:0] a, input logic [7:0] d);
        aram_wr  = 1'b1;
        aram_a   = a;
        aram_din = d;
        tick();
        aram_wr  = 1'b0;
        ref_aram[a] = d;
    endtask

    task automatic buildHdr(input logic [7:0] tag, input string len_s, input string fade_s,
                            input int bad_idx);
        string sig;
        sig = "SNES-SPC700";
        for (int i = 0; i < 256; i++) hdr[i] = 8'($urandom);
        for (int i = 0; i < 11; i++) hdr[i] = sig[i];
        if (bad_idx >= 0) hdr[bad_idx] = "X";
        hdr[8'h23] = tag;
        for (int i = 0; i < LEN_DIGITS; i++)
            hdr[8'hA9 + i] = (i < len_s.len()) ? len_s[i] : 8'h00;
        for (int i = 0; i < FADE_DIGITS; i++)
            hdr[8'hAC + i] = (i < fade_s.len()) ? fade_s[i] : 8'h00;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] rd;
        string      ls;
        string      fs;
        int         el;
        int         ef;

        vecs[0] = mkVec(-1, 8'h1A, "120", "08000", 1'b0, 120, 8000);
        vecs[1] = mkVec(-1, 8'h1A, "45",  "99999", 1'b0, 45,  65535);
        vecs[2] = mkVec(-1, 8'h1B, "120", "08000", 1'b0, 20,  3000);
        vecs[3] = mkVec(-1, 8'h1A, "x12", "7a",    1'b0, 20,  7);
        vecs[4] = mkVec( 5, 8'h1A, "120", "08000", 1'b1, 20,  3000);
        vecs[5] = mkVec(-1, 8'h1A, "999", "65536", 1'b0, 999, 65535);
        vecs[6] = mkVec( 0, 8'h1A, "120", "08000", 1'b1, 20,  3000);
        vecs[7] = mkVec(10, 8'h1A, "120", "08000", 1'b1, 20,  3000);

        reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        aram_a = '0; aram_din = '0; aram_wr = 1'b0; dsp_a = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_flags", {ld_ready, ld_busy, ld_done, ld_err}, 4'b0000);
        checkOutput("reset_regs", spc_regs, 56'h0);
        checkOutput("reset_length", length, 64'(DEF_LENGTH));
        checkOutput("reset_fade", fade, 64'(DEF_FADE));
        checkOutput("reset_douts", {aram_dout, dsp_dout}, 16'h0000);
        reset = 1'b0;
        tick();

        for (int a = 0; a < 16; a++) writeAram(16'(a), 8'($urandom));

        // Header variants: each streams through the header and 16 ARAM bytes.
        for (int k = 0; k < 8; k++) begin
            buildHdr(vecs[k].tag, vecs[k].len_s, vecs[k].fade_s, vecs[k].bad_idx);
            startLoad();
            for (int off = 0; off < 'h110; off++) begin
                d = (off < 256) ? hdr[off] : 8'($urandom);
                if (off >= 256 && !vecs[k].exp_err) ref_aram[off - 256] = d;
                applyStimulus(1'b1, d);
            end
            ld_valid = 1'b0;
            checkOutput($sformatf("vec%0d_err", k), ld_err, 64'(vecs[k].exp_err));
            checkOutput($sformatf("vec%0d_ready", k), ld_ready, 64'(!vecs[k].exp_err));
            checkOutput($sformatf("vec%0d_length", k), length,
                        64'(ID_EN ? vecs[k].exp_len : DEF_LENGTH));
            checkOutput($sformatf("vec%0d_fade", k), fade,
                        64'(ID_EN ? vecs[k].exp_fade : DEF_FADE));
            if (vecs[k].exp_err) begin
                for (int a = 0; a < 4; a++) begin
                    readAram(16'(a), rd);
                    checkOutput($sformatf("vec%0d_aram%0d", k, a), rd, 64'(ref_aram[a]));
                end
            end else begin
                checkOutput($sformatf("vec%0d_regs", k), spc_regs, 64'(expRegs()));
            end
        end

        // Reset in the middle of the ARAM region.
        writeAram(16'h0F00, 8'hC3);
        buildHdr(8'h1A, "120", "08000", -1);
        startLoad();
        for (int off = 0; off < 'h1000; off++) begin
            d = (off < 256) ? hdr[off] : 8'($urandom);
            if (off >= 256) ref_aram[off - 256] = d;
            applyStimulus(1'b1, d);
        end
        ld_data = 8'hEE;
        reset = 1'b1;
        #2;
        checkOutput("abort_flags", {ld_ready, ld_busy, ld_done, ld_err}, 4'b0000);
        checkOutput("abort_regs", spc_regs, 56'h0);
        checkOutput("abort_len_fade", {length, fade}, {16'(DEF_LENGTH), 16'(DEF_FADE)});
        checkOutput("abort_douts", {aram_dout, dsp_dout}, 16'h0000);
        tick();
        reset = 1'b0;
        repeat (16) applyStimulus(1'b1, 8'hEE);
        ld_valid = 1'b0;
        checkOutput("abort_idle_busy", ld_busy, 1'b0);
        readAram(16'h0F00, rd);
        checkOutput("abort_no_write", rd, 8'hC3);
        readAram(16'h0010, rd);
        checkOutput("abort_kept", rd, 64'(ref_aram[16'h0010]));

        // Full load with random digit fields and SMP writes attempted mid-load.
        ls = "000";
        fs = "00000";
        for (int i = 0; i < 3; i++) ls[i] = 8'(48 + $urandom_range(0, 9));
        for (int i = 0; i < 5; i++) fs[i] = 8'(48 + $urandom_range(0, 9));
        el = expField(ls, LEN_DIGITS, DEF_LENGTH, 8'h1A);
        ef = expField(fs, FADE_DIGITS, DEF_FADE, 8'h1A);
        buildHdr(8'h1A, ls, fs, -1);
        readAram(16'h0F00, rd);
        startLoad();
        for (int off = 0; off < 'h10180; off++) begin
            if (off < 256) begin
                d = hdr[off];
            end else if (off < 'h10100) begin
                d = (off == 'h1234) ? 8'h5A : 8'($urandom);
                ref_aram[16'(off - 256)] = d;
            end else begin
                d = 8'($urandom);
                ref_dsp[off - 'h10100] = d;
            end
            if (off == 'h1300) begin
                aram_wr = 1'b1; aram_a = 16'h1134; aram_din = 8'hA5;
            end
            if (off == 'h1310) aram_wr = 1'b0;
            if (off == 'h10000) begin
                checkOutput("load_mid_flags", {ld_ready, ld_busy, ld_done, ld_err}, 4'b1100);
                checkOutput("load_dout_hold", aram_dout, 8'hC3);
            end
            if (off == 'h1017F)
                checkOutput("load_last_flags", {ld_ready, ld_busy, ld_done, ld_err}, 4'b1100);
            applyStimulus(1'b1, d);
        end
        ld_valid = 1'b0;
        checkOutput("load_done_flags", {ld_ready, ld_busy, ld_done, ld_err}, 4'b0010);
        checkOutput("load_length", length, 64'(el));
        checkOutput("load_fade", fade, 64'(ef));
        checkOutput("load_regs", spc_regs, 64'(expRegs()));
        readAram(16'h1134, rd);
        checkOutput("aram_1134", rd, 8'h5A);
        readAram(16'hFFFF, rd);
        checkOutput("aram_ffff", rd, 64'(ref_aram[16'hFFFF]));

        // Random SMP and DSP traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [15:0] a;
            logic [6:0]  da;
            op = $urandom_range(0, 2);
            a  = 16'($urandom);
            da = 7'($urandom);
            if (op == 0) begin
                writeAram(a, 8'($urandom));
            end else if (op == 1) begin
                readAram(a, rd);
                checkOutput($sformatf("rand_aram_%04h", a), rd, 64'(ref_aram[a]));
            end else begin
                dsp_a = da;
                tick();
                checkOutput($sformatf("rand_dsp_%02h", da), dsp_dout, 64'(ref_dsp[da]));
            end
        end

        // Restart from DONE.
        startLoad();
        checkOutput("restart_flags", {ld_ready, ld_busy, ld_done, ld_err}, 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
